// File: rtl/stopwatch_defs_pkg.sv
// rtl/stopwatch_defs_pkg.sv - shared FSM encoding and digit limits for the stopwatch
package stopwatch_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int DIG_LIM_DEC      = 9;
    localparam int DIG_LIM_TENS_SEC = 5;

endpackage

// File: rtl/lim_inc.sv
// rtl/lim_inc.sv - limited incrementer: a+ci, wrapping to 0 with carry when above L
module lim_inc #(
    parameter int L = 9,
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    localparam logic [W:0] LIM = (W+1)'(L);

    logic [W:0] inc;

    // Out-of-range inputs also land here, so a corrupted digit self-heals to 0.
    always_comb begin
        inc = {1'b0, a} + {{W{1'b0}}, ci};
        sum = inc[W-1:0];
        co  = 1'b0;
        if (inc > LIM) begin
            sum = '0;
            co  = 1'b1;
        end
    end

endmodule

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enabled prescaler issuing one tick every DIV enabled cycles
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Holding while disabled keeps the sub-tick phase across a pause.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/idle stopwatch sequencer driving an SS.hh digit cascade
module stopwatch_ctrl
    import stopwatch_defs::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int TICK_HZ  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       running,
    output logic       wrap
);

    localparam int DIV = CLK_FREQ / TICK_HZ;

    if (DIV < 2) begin : g_div_check
        $error("stopwatch_ctrl: CLK_FREQ/TICK_HZ must be at least 2");
    end

    sw_state_t  state;
    logic       run_en;
    logic       clr_cmd;
    logic       tick;
    logic [3:0] d0_q, d1_q, d2_q;
    logic [2:0] d3_q;
    logic [3:0] s0, s1, s2;
    logic [2:0] s3;
    logic       co0, co1, co2, co3;

    assign run_en  = (state == ST_RUN);
    // clear only acts outside RUN, where it also beats a simultaneous start_stop.
    assign clr_cmd = clear && (state != ST_RUN);

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .clr   (clr_cmd),
        .tick  (tick)
    );

    lim_inc #(.L(DIG_LIM_DEC), .W(4)) u_inc0 (.a(d0_q), .ci(tick), .sum(s0), .co(co0));
    lim_inc #(.L(DIG_LIM_DEC), .W(4)) u_inc1 (.a(d1_q), .ci(co0),  .sum(s1), .co(co1));
    lim_inc #(.L(DIG_LIM_DEC), .W(4)) u_inc2 (.a(d2_q), .ci(co1),  .sum(s2), .co(co2));
    lim_inc #(.L(DIG_LIM_TENS_SEC), .W(3)) u_inc3 (.a(d3_q), .ci(co2), .sum(s3), .co(co3));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!clear && start_stop) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start_stop) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (clear) begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end else if (start_stop) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_cmd) begin
            d0_q <= '0;
            d1_q <= '0;
            d2_q <= '0;
            d3_q <= '0;
            wrap <= 1'b0;
        end else begin
            d0_q <= s0;
            d1_q <= s1;
            d2_q <= s2;
            d3_q <= s3;
            wrap <= co3;
        end
    end

    assign d0 = d0_q;
    assign d1 = d1_q;
    assign d2 = d2_q;
    assign d3 = {1'b0, d3_q};

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed, table-driven bench for stopwatch_ctrl at DIV=4
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] d0, d1, d2, d3;
    logic       running, wrap;

    int checks = 0;
    int failures = 0;
    int wrap_seen = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CLK_FREQ(40), .TICK_HZ(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .running    (running),
        .wrap       (wrap)
    );

    typedef struct {
        logic ss;
        logic clr;
        logic rst;
        logic exp_run;
        int   exp_d0;
        logic exp_wrap;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic c, input logic r);
        start_stop = s;
        clear      = c;
        reset      = r;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        reset      = 1'b0;
        if (wrap) wrap_seen++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_digits(input string name, input int e3, input int e2, input int e1, input int e0);
        check({name, "_digits"}, {d3, d2, d1, d0}, (e3 << 12) | (e2 << 8) | (e1 << 4) | e0);
    endtask

    int frozen_bad;

    initial begin
        //                 ss    clr   rst   run   d0  wrap
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};

        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("reset_running", running, 0);
        check("reset_wrap", wrap, 0);
        check_digits("reset", 0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].ss, vecs[i].clr, vecs[i].rst);
            check($sformatf("vec%0d_running", i), running, vecs[i].exp_run);
            check($sformatf("vec%0d_d0", i), d0, vecs[i].exp_d0);
            check($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
        end

        // Start at cycle 10 after reset; first tick DIV cycles later.
        step(1'b0, 1'b0, 1'b1);
        wrap_seen = 0;
        run(9);
        check("a_idle_running", running, 0);
        step(1'b1, 1'b0, 1'b0);
        check("a_running", running, 1);
        run(3);
        check("a_d0_before_tick", d0, 0);
        run(1);
        check("a_d0_first", d0, 1);
        run(4);
        check("a_d0_second", d0, 2);
        check("a_no_wrap", wrap_seen, 0);

        // Long run through 00.10, 00.99, 01.00 and 59.99 rollover.
        step(1'b0, 1'b0, 1'b1);
        wrap_seen = 0;
        step(1'b1, 1'b0, 1'b0);
        run(39);
        check_digits("b_0009", 0, 0, 0, 9);
        run(1);
        check_digits("b_0010", 0, 0, 1, 0);
        run(356);
        check_digits("b_0099", 0, 0, 9, 9);
        run(4);
        check_digits("b_0100", 0, 1, 0, 0);
        run(23596);
        check_digits("c_5999", 5, 9, 9, 9);
        check("c_no_early_wrap", wrap_seen, 0);
        run(3);
        check("c_wrap_pre", wrap, 0);
        run(1);
        check_digits("c_rollover", 0, 0, 0, 0);
        check("c_wrap_pulse", wrap, 1);
        check("c_running_kept", running, 1);
        run(1);
        check("c_wrap_single", wrap, 0);
        run(3);
        check_digits("c_0001", 0, 0, 0, 1);
        check("c_wrap_count", wrap_seen, 1);

        // Pause with prescaler at 2 on 00.03, hold, resume.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        run(13);
        step(1'b1, 1'b0, 1'b0);
        check("d_paused_running", running, 0);
        check("d_paused_d0", d0, 3);
        frozen_bad = 0;
        for (int k = 0; k < 20; k++) begin
            run(1);
            if (d0 != 4'd3 || d1 != 4'd0 || running != 1'b0) frozen_bad++;
        end
        check("d_frozen", frozen_bad, 0);
        step(1'b1, 1'b0, 1'b0);
        check("d_resume_running", running, 1);
        run(1);
        check("d_resume_1", d0, 3);
        run(1);
        check("d_resume_2", d0, 4);

        // start_stop + clear together in RUN, then in PAUSE.
        step(1'b1, 1'b1, 1'b0);
        check("e_run_pair_running", running, 0);
        check_digits("e_run_pair", 0, 0, 0, 4);
        step(1'b1, 1'b1, 1'b0);
        check("e_pause_pair_running", running, 0);
        check_digits("e_pause_pair", 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        run(3);
        check("e_presc_zero_a", d0, 0);
        run(1);
        check("e_presc_zero_b", d0, 1);

        // Reset on a tick cycle at 00.07 discards that tick.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        run(28);
        check_digits("f_0007", 0, 0, 0, 7);
        run(3);
        step(1'b0, 1'b0, 1'b1);
        check_digits("f_reset", 0, 0, 0, 0);
        check("f_reset_running", running, 0);
        check("f_reset_wrap", wrap, 0);
        run(5);
        check_digits("f_idle_hold", 0, 0, 0, 0);
        check("f_idle_running", running, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for a 4-digit stopwatch (SS.hh, 00.00 to 59.99) on the BASYS3 lab board. It owns a run/pause/idle FSM and a clock prescaler that issues 1/100 s ticks. It drives a cascade of four instances of the team's limited incrementer, Lim_Inc: the hundredths, tenths and seconds digits use L=9, and the tens-of-seconds digit uses L=5. Digit outputs feed the existing 7-segment display mux.

Parameters:
CLK_FREQ, 100000000, input clock frequency in Hz.
TICK_HZ, 100, count rate in Hz. DIV = CLK_FREQ/TICK_HZ must be >= 2. Elaboration fails otherwise.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start_stop  input  1  one-cycle pulse, already debounced upstream; toggles run/pause.
clear  input  1  one-cycle pulse, already debounced upstream; zeroes the count when not running.
d0  output  4  hundredths digit, 0..9.
d1  output  4  tenths digit, 0..9.
d2  output  4  seconds digit, 0..9.
d3  output  4  tens-of-seconds digit, 0..5.
running  output  1  high while the FSM is in RUN.
wrap  output  1  one-cycle pulse when the count rolls over from 59.99 to 00.00.

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE; prescaler=0; d0..d3=0; running=0; wrap=0. Reset overrides every other input on that edge.
- FSM states: IDLE, RUN, PAUSE. running = (state==RUN), registered.
- Transitions:
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN.
  - PAUSE + clear -> IDLE.
  - IDLE + clear -> IDLE (no-op).
- clear is ignored in RUN.
- start_stop and clear together:
  - In RUN, start_stop is taken (-> PAUSE) and clear is ignored.
  - In IDLE or PAUSE, clear wins and start_stop is ignored.
- Prescaler: width $clog2(DIV).
  - Increments only in RUN and wraps DIV-1 -> 0.
  - Holds its value in PAUSE, so sub-tick time is preserved across a pause.
  - Zeroed on clear-to-IDLE and on reset.
- Tick: combinational, tick = (state==RUN) && (prescaler==DIV-1).
  - tick is evaluated on the current state. If start_stop arrives on a tick cycle, that tick is still counted and the FSM enters PAUSE on the same edge.
- Digit cascade: combinational Lim_Inc chain with registered digit outputs.
  - d0: ci=tick. d1: ci=co0. d2: ci=co1. d3: ci=co2. Each next value is loaded into its register on the edge.
  - Latency: digits change on the edge that ends the tick cycle. The first tick after entering RUN occurs DIV cycles after the start_stop edge.
- Rollover: co3=1 only when the count is 59.99 and tick=1. On that edge all digits become 0 and wrap=1 for exactly one cycle. Counting continues in RUN.
- Width rules:
  - d0..d3 are 4 bits. Lim_Inc with L=9 is 4 bits wide; the L=5 instance is 3 bits wide and zero-extended onto d3.
  - Digit registers never hold out-of-range values. Any out-of-range value (e.g. after an SEU) saturates to 0 with carry, per Lim_Inc semantics.
- Reset mid-operation: reset in RUN or PAUSE returns to the full reset state on that edge. A tick in the same cycle is discarded.
- Outputs are stable between ticks. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package/header (stopwatch_defs): FSM state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2); digit limits DIG_LIM_DEC=9 and DIG_LIM_TENS_SEC=5.
- Sub-module tick_gen:
  - Contents: prescaler with enable, sync clear and tick output; parameter DIV.
  - Reuse: the same unit is reused by the display-mux refresh.
- The top level holds the FSM, the four Lim_Inc instances and the digit registers.

Test Plan (bench uses CLK_FREQ=40, TICK_HZ=10 -> DIV=4):
- Reset then start_stop at cycle 10 -> running=1 from cycle 11; d0=1 after 4 cycles and d0=2 after 8; no wrap.
- Run 10 ticks from 00.00 -> d1=1, d0=0 on the 10th tick edge. Preload to 00.99 and tick -> 01.00.
- Preload 59.99 in RUN, one tick -> d3..d0=0, wrap=1 for exactly one cycle, running stays 1. The next tick gives 00.01.
- Pause at prescaler=2 with 00.03, hold 20 cycles, resume -> digits frozen at 00.03 during pause; d0=4 exactly 2 cycles after the resume edge.
- start_stop and clear together in RUN -> PAUSE with digits held. Same pair in PAUSE -> IDLE, all digits 0, prescaler 0, running=0.
- Assert reset during RUN on a tick cycle at 00.07 -> next cycle: digits 0, IDLE, wrap=0, the tick is not applied.
